// File: rtl/vec_alu_sequencer_pkg.sv
// Shared opcodes, sequencer states and flag bit positions for the vector ALU sequencer.
package vec_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_W = 4;
endpackage

// File: rtl/vec_alu_sequencer_flag_acc.sv
// Flag accumulator: OR-merges carry/neg/ovf and AND-merges zero over the masked lanes of each beat.
module vec_seq_flag_acc
  import vec_seq_pkg::*;
#(
  parameter int NUM_ALU = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic [NUM_ALU-1:0]       i_mask,
  input  logic [NUM_ALU*FLG_W-1:0] i_flags,
  output logic [FLG_W-1:0]         o_flags
);
  logic [FLG_W-1:0] r_acc;
  logic [FLG_W-1:0] w_merge;

  always_comb begin
    w_merge = r_acc;
    for (int j = 0; j < NUM_ALU; j++) begin
      if (i_mask[j]) begin
        w_merge[FLG_C] = w_merge[FLG_C] | i_flags[j*FLG_W+FLG_C];
        w_merge[FLG_Z] = w_merge[FLG_Z] & i_flags[j*FLG_W+FLG_Z];
        w_merge[FLG_N] = w_merge[FLG_N] | i_flags[j*FLG_W+FLG_N];
        w_merge[FLG_V] = w_merge[FLG_V] | i_flags[j*FLG_W+FLG_V];
      end
    end
  end

  // zero starts at 1 so the AND over lanes reflects "every merged lane was zero"
  always_ff @(posedge clk) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= FLG_W'(1) << FLG_Z;
    else if (i_en)  r_acc <= w_merge;
  end

  assign o_flags = r_acc;
endmodule

// File: rtl/vec_alu_sequencer.sv
// Issues one vector op over NUM_ALU shared lanes, one beat per cycle, and gathers results and flags.
// Optional VEC_SEQ_PERF_EN adds perf_ops / perf_busy counters.
module vec_alu_sequencer
  import vec_seq_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int NUM_ALU = 2,
  parameter int DATA_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op_code,
  input  logic                       op_scalar,
  input  logic [VEC_LEN*DATA_W-1:0]  op_a,
  input  logic [VEC_LEN*DATA_W-1:0]  op_b,
  output logic [NUM_ALU*DATA_W-1:0]  alu_a,
  output logic [NUM_ALU*DATA_W-1:0]  alu_b,
  output logic [2:0]                 alu_opcode,
  output logic                       alu_scalar,
  output logic [NUM_ALU*32-1:0]      alu_inst,
  input  logic [NUM_ALU*DATA_W-1:0]  alu_result,
  input  logic [NUM_ALU*FLG_W-1:0]   alu_flags,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [VEC_LEN*DATA_W-1:0]  res_vec,
  output logic [FLG_W-1:0]           res_flags
`ifdef VEC_SEQ_PERF_EN
  ,
  output logic [31:0]                perf_ops,
  output logic [31:0]                perf_busy
`endif
);
  localparam int BEATS = VEC_LEN / NUM_ALU;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e                      r_state;
  logic [BW-1:0]               r_beat;
  logic [2:0]                  r_op;
  logic                        r_scalar;
  logic [VEC_LEN*DATA_W-1:0]   r_a, r_b, r_res;

  logic                        w_issue, w_accept;
  logic [NUM_ALU-1:0]          w_mask;
  logic [NUM_ALU-1:0][31:0]    w_idx;

  assign w_issue    = (r_state == ISSUE);
  assign w_accept   = (r_state == IDLE) && op_valid;
  assign op_ready   = (r_state == IDLE);
  assign res_valid  = (r_state == DONE);
  assign res_vec    = r_res;
  assign alu_opcode = w_issue ? r_op : 3'b000;
  assign alu_scalar = w_issue & r_scalar;

  // Lane j of beat b carries global element b*NUM_ALU+j; scalar ops keep only lane 0.
  for (genvar j = 0; j < NUM_ALU; j++) begin : g_lane
    assign w_idx[j]  = 32'(r_beat) * 32'(NUM_ALU) + 32'(j);
    assign w_mask[j] = (j == 0) || !r_scalar;
    assign alu_a[j*DATA_W +: DATA_W] = w_issue ? r_a[w_idx[j]*32'(DATA_W) +: DATA_W] : '0;
    assign alu_b[j*DATA_W +: DATA_W] = w_issue ? r_b[w_idx[j]*32'(DATA_W) +: DATA_W] : '0;
    assign alu_inst[j*32 +: 32]      = w_issue ? w_idx[j] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_op     <= '0;
      r_scalar <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
    end else begin
      case (r_state)
        IDLE: if (op_valid) begin
          r_op     <= op_code;
          r_scalar <= op_scalar;
          r_a      <= op_a;
          r_b      <= op_b;
          r_res    <= '0;
          r_beat   <= '0;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          for (int j = 0; j < NUM_ALU; j++)
            if (w_mask[j]) r_res[w_idx[j]*32'(DATA_W) +: DATA_W] <= alu_result[j*DATA_W +: DATA_W];
          if (r_beat == BW'(BEATS-1) || r_scalar) begin
            r_beat  <= '0;
            r_state <= DONE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        DONE: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  vec_seq_flag_acc #(.NUM_ALU(NUM_ALU)) u_flag_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_en    (w_issue),
    .i_mask  (w_mask),
    .i_flags (alu_flags),
    .o_flags (res_flags)
  );

`ifdef VEC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (res_valid && res_ready) perf_ops  <= perf_ops + 32'd1;
      if (r_state != IDLE)        perf_busy <= perf_busy + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with a behavioural two-lane Q7.8 ALU model.
module tb_vec_alu_sequencer;
  import vec_seq_pkg::*;

  localparam int VL = 8, NA = 2, DW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic op_valid = 1'b0, op_ready, op_scalar = 1'b0, res_ready = 1'b0, res_valid, alu_scalar;
  logic [2:0] op_code = 3'b000, alu_opcode;
  logic [VL*DW-1:0] op_a = '0, op_b = '0, res_vec;
  logic [NA*DW-1:0] alu_a, alu_b, alu_result;
  logic [NA*32-1:0] alu_inst;
  logic [NA*4-1:0]  alu_flags;
  logic [3:0]       res_flags;
`ifdef VEC_SEQ_PERF_EN
  logic [31:0] perf_ops, perf_busy;
`endif

  always #5 clk = ~clk;

  vec_alu_sequencer #(.VEC_LEN(VL), .NUM_ALU(NA), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_scalar(op_scalar), .op_a(op_a), .op_b(op_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_scalar(alu_scalar), .alu_inst(alu_inst),
    .alu_result(alu_result), .alu_flags(alu_flags), .res_valid(res_valid),
    .res_ready(res_ready), .res_vec(res_vec), .res_flags(res_flags)
`ifdef VEC_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  // Lane model; carry is the carry (add) or borrow (sub) into bit 15, zero for mul.
  function automatic logic [19:0] lane(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, lo;
    logic c, v;
    logic signed [31:0] p;
    r = '0; lo = '0; c = 1'b0; v = 1'b0; p = '0;
    case (op)
      OP_ADD: begin
        r = a + b; lo = {1'b0, a[14:0]} + {1'b0, b[14:0]}; c = lo[15];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        r = a - b; c = (a[14:0] < b[14:0]);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_MUL: begin
        p = ($signed(a) * $signed(b)) >>> 8; r = p[15:0];
        v = (p != 32'($signed(r)));
      end
      default: ;
    endcase
    return {v, r[15], (r == 16'h0), c, r};
  endfunction

  // Scalar ops on non-zero instances return garbage that must never be stored or merged.
  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    for (int j = 0; j < NA; j++) begin
      if (alu_scalar && alu_inst[j*32 +: 32] != 32'd0)
        {alu_flags[j*4 +: 4], alu_result[j*16 +: 16]} = {4'hF, 16'hDEAD};
      else
        {alu_flags[j*4 +: 4], alu_result[j*16 +: 16]} = lane(alu_opcode, alu_a[j*16 +: 16], alu_b[j*16 +: 16]);
    end
  end

  typedef struct {
    logic [2:0]       op;
    logic             sc;
    logic [VL*DW-1:0] a, b, exp;
    logic [3:0]       fl;
    int               lat;
  } vec_t;

  vec_t vecs[8];
  int checks = 0, errors = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Waits for res_valid after a handshake edge; tracks cycle number and lane instance mapping.
  task automatic wait_res(output int cyc, output bit inst_bad);
    logic [63:0] ei;
    cyc = 1; inst_bad = 1'b0;
    while (!res_valid && cyc < 40) begin
      ei = {32'((cyc-1)*2 + 1), 32'((cyc-1)*2)};
      if (alu_inst !== ei) inst_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic drive(input vec_t v);
    op_code = v.op; op_scalar = v.sc; op_a = v.a; op_b = v.b; op_valid = 1'b1;
  endtask

  task automatic handoff(input string nm);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({nm, " handoff"}, {126'h0, res_valid, op_ready}, 128'h1);
  endtask

  initial begin
    int cyc;
    bit ib, st_ok;
    logic [127:0] snap;

    vecs[0] = '{OP_ADD, 1'b0, {8{16'h0100}}, {8{16'h0200}}, {8{16'h0300}}, 4'b0000, 5};
    vecs[1] = '{OP_SUB, 1'b0, {8{16'h1234}}, {8{16'h1234}}, 128'h0, 4'b0010, 5};
    vecs[2] = '{OP_MUL, 1'b1, {{7{16'h1111}}, 16'h0200}, {{7{16'h2222}}, 16'h0300},
                {112'h0, 16'h0600}, 4'b0000, 2};
    vecs[3] = '{OP_ADD, 1'b0, 128'h0000_0000_0000_0000_7FFF_0000_0000_0000,
                128'h0000_0000_0000_0000_0001_0000_0000_0000,
                128'h0000_0000_0000_0000_8000_0000_0000_0000, 4'b1101, 5};
    vecs[4] = '{3'b101, 1'b0, {8{16'h4321}}, {8{16'h0777}}, 128'h0, 4'b0010, 5};
    vecs[5] = '{OP_ADD, 1'b0, 128'h0008_0007_0006_0005_0004_0003_0002_0001,
                128'h0700_0600_0500_0400_0300_0200_0100_0000,
                128'h0708_0607_0506_0405_0304_0203_0102_0001, 4'b0000, 5};
    vecs[6] = '{OP_SUB, 1'b0, 128'h0, 128'h0008_0007_0006_0005_0004_0003_0002_0001,
                128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF, 4'b0101, 5};
    vecs[7] = '{OP_MUL, 1'b0, {8{16'hFF00}}, {8{16'h0200}}, {8{16'hFE00}}, 4'b0100, 5};

    repeat (2) @(posedge clk);
    #1;
    check("reset ctl", {125'h0, op_ready, res_valid, alu_scalar}, 128'b100);
    check("reset data", {res_vec[63:0], alu_a, alu_inst[31:0]}, 128'h0);
    check("reset flags", {124'h0, res_flags}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      @(posedge clk); #1;
      op_valid = 1'b0;
      wait_res(cyc, ib);
      check($sformatf("v%0d latency", i), 128'(cyc), 128'(vecs[i].lat));
      check($sformatf("v%0d res_vec", i), res_vec, vecs[i].exp);
      check($sformatf("v%0d res_flags", i), {124'h0, res_flags}, {124'h0, vecs[i].fl});
      check($sformatf("v%0d alu_inst", i), {127'h0, ib}, 128'h0);
      handoff($sformatf("v%0d", i));
    end

    // Back-pressure: result held, no acceptance until one cycle after the handoff.
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[5]);
    wait_res(cyc, ib);
    snap = vecs[0].exp;
    st_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_vec !== snap || op_ready !== 1'b0 || res_valid !== 1'b1 || res_flags !== 4'b0000) st_ok = 1'b0;
    end
    check("bp hold", {127'h0, st_ok}, 128'h1);
    handoff("bp");
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("bp accept", {127'h0, op_ready}, 128'h0);
    wait_res(cyc, ib);
    check("bp second vec", res_vec, vecs[5].exp);
    check("bp second lat", 128'(cyc), 128'd5);
    handoff("bp2");

    // Synchronous reset while beat 2 is on the lanes.
    drive(vecs[5]);
    repeat (3) begin @(posedge clk); #1; op_valid = 1'b0; end
    check("mid beat2 inst", {64'h0, alu_inst}, {64'h0, 32'd5, 32'd4});
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid rst ctl", {126'h0, op_ready, res_valid}, 128'b10);
    check("mid rst vec", res_vec, 128'h0);
    check("mid rst lanes", {alu_a, alu_b, alu_inst}, 128'h0);
    check("mid rst flags", {124'h0, res_flags}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(vecs[3]);
    @(posedge clk); #1;
    op_valid = 1'b0;
    wait_res(cyc, ib);
    check("post rst vec", res_vec, vecs[3].exp);
    check("post rst flags", {124'h0, res_flags}, {124'h0, vecs[3].fl});
    handoff("post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
